wb_trace_buf: RTL

WB_TRACE_BUF -- requirements
Module: wb_trace_buf

---
 rtl/wb_trace_buf.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_trace_buf.sv
// Write-back trace buffer: stamps stage-4 write-back events and queues them in a
// FIFO, under an arm / trigger / post-trigger / freeze capture controller.
module wb_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int POST_CNT  = 4,
  parameter int DATA_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int CODE_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CODE_SIZE-1:0]   wb_code,
  input  logic [REG_SIZE-1:0]    wb_reg,
  input  logic [DATA_SIZE-1:0]   wb_data,
  input  logic                   arm,
  input  logic                   clr,
  input  logic                   trig_en,
  input  logic [REG_SIZE-1:0]    trig_reg,
  input  logic                   tr_ready,
  output logic                   tr_valid,
  output logic [15:0]            tr_stamp,
  output logic [CODE_SIZE-1:0]   tr_code,
  output logic [REG_SIZE-1:0]    tr_reg,
  output logic [DATA_SIZE-1:0]   tr_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [1:0]             state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [7:0]  POST_LOAD  = 8'(POST_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_t;

  state_t          fsm;
  logic [7:0]      post_left;
  logic [15:0]     cycle_cnt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;

  logic [15:0]          stamp_mem [DEPTH];
  logic [CODE_SIZE-1:0] code_mem  [DEPTH];
  logic [REG_SIZE-1:0]  reg_mem   [DEPTH];
  logic [DATA_SIZE-1:0] data_mem  [DEPTH];

  logic is_event;
  logic capturing;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic trig_hit;

  // A full FIFO still accepts an event when the head leaves in the same cycle.
  always_comb begin
    is_event  = (wb_code != '0);
    capturing = is_event && ((fsm == RUN) || (fsm == POST));
    full      = (count == FULL_LEVEL);
    pop       = tr_valid && tr_ready;
    push      = capturing && (!full || pop);
    drop      = capturing && full && !pop;
    trig_hit  = (fsm == RUN) && is_event && trig_en && (wb_reg == trig_reg);
  end

  assign tr_valid = (count != '0);
  assign level    = count;
  assign state    = fsm;
  assign tr_stamp = tr_valid ? stamp_mem[rd_ptr] : '0;
  assign tr_code  = tr_valid ? code_mem[rd_ptr]  : '0;
  assign tr_reg   = tr_valid ? reg_mem[rd_ptr]   : '0;
  assign tr_data  = tr_valid ? data_mem[rd_ptr]  : '0;

  // Timestamp source keeps counting through clr so stamps stay monotonic.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= 16'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the read mux masks stale contents while empty.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) begin
      stamp_mem[wr_ptr] <= cycle_cnt;
      code_mem[wr_ptr]  <= wb_code;
      reg_mem[wr_ptr]   <= wb_reg;
      data_mem[wr_ptr]  <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // The trigger event itself does not count toward the post-trigger window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fsm       <= IDLE;
      post_left <= 8'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (arm) begin
            fsm <= RUN;
          end
        end
        RUN: begin
          if (trig_hit) begin
            if (POST_CNT == 0) begin
              fsm <= FROZEN;
            end else begin
              fsm       <= POST;
              post_left <= POST_LOAD;
            end
          end
        end
        POST: begin
          if (is_event) begin
            post_left <= post_left - 8'd1;
            if (post_left == 8'd1) begin
              fsm <= FROZEN;
            end
          end
        end
        FROZEN: begin
          if (arm) begin
            fsm <= RUN;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
